alu_math_p: RTL
===============

# alu_math_p

Parametrised byte-serial arithmetic unit, successor to the fixed 16-bit math unit on the ALU command path. It accepts an opcode and OP_BYTES-wide operands over an 8-bit serial port and computes k*f(A,B)+c. It adds configurable operand and result widths, an iterative divider, a busy indication, and error reporting for illegal opcodes, divide-by-zero and protocol violations.

## Interface
- OP_BYTES, 2: operand width in bytes, range 1..4; OP_W = 8*OP_BYTES.
- RES_W, 32: result width; must be ≥ 2*OP_W.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- ctl  in  1  opcode strobe; high only in the opcode cycle.
- dat  in  8  opcode (low 4 bits) or operand byte, MSB first.
- k_val  in  8  multiplier k, quasi-static.
- c_val  in  8  offset c, quasi-static.
- result  out  RES_W  last result; reset 0.
- ready  out  1  one-cycle pulse when result/err_code are valid; reset 0.
- busy  out  1  high whenever FSM ≠ IDLE; reset 0.
- err  out  1  one-cycle error pulse; reset 0.
- err_code  out  2  0 none, 1 illegal opcode, 2 divide by zero, 3 protocol; reset 0; holds until next err.

## Operation
- ctl, dat, k_val and c_val are registered once (ctl_r, dat_r, ...) before any use.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB_AB: A−B.
  - 2 SUB_BA: B−A.
  - 3 MUL: A*B.
  - 4 DIV_AB: A/B.
  - 5 DIV_BA: B/A.
  - 6 INC_A: A+1 (operands A only).
  - 7 INC_B: B+1 (operands B only).
  - 8 CLR: result=0 (no operands).
  - 9 ACCUM: result+A, with no k/c (operands A only).
  - 10..15: illegal.
- FSM: IDLE → OP_A (OP_BYTES cycles, byte counter) → OP_B (OP_BYTES cycles) → COMPUTE → [MUL_S | DIV_S] → RESULT → IDLE.
  - OP_A or OP_B is skipped when the opcode does not use it.
  - CLR goes straight to COMPUTE.
  - MUL_S lasts 1 cycle.
  - DIV_S waits for divider done, which takes OP_W cycles.
- Command accepted only in IDLE with ctl_r=1.
  - Illegal opcode: err pulse with err_code=1; FSM stays IDLE; result unchanged.
- ctl_r=1 in any non-IDLE state: err pulse with err_code=3; strobe ignored; the command in flight completes normally.
- Arithmetic:
  - Operands are zero-extended.
  - All operations are modulo 2^RES_W, so subtraction wraps in two's complement.
  - Final value = k_val_r*f + c_val_r, truncated to RES_W.
  - k_val_r and c_val_r are sampled in COMPUTE.
  - Quotient is truncating unsigned.
- Divide by zero: ready pulses with err=1 and err_code=2; result unchanged.
- Successful completion: err_code cleared to 0 in the ready cycle.
- ACCUM uses the current result register; a CLR followed by ACCUMs gives a running sum.

## Timing
- u = input cycle of the last operand byte (opcode cycle for CLR).
  - COMPUTE in u+2.
  - RESULT in u+3 for ADD/SUB/INC/CLR/ACCUM; u+4 for MUL; u+4+OP_W for DIV.
- ready and the new result are visible in the RESULT cycle; busy drops in the following cycle.
- Earliest next opcode at input: the ready cycle. A strobe one cycle earlier is a protocol error.
- Operand bytes must arrive on consecutive cycles immediately after the opcode; no gaps.
- err pulse for illegal/protocol errors appears 2 cycles after the offending input cycle.
- Reset asserted at any point:
  - All outputs go to 0 immediately.
  - FSM goes to IDLE and the divider aborts.
  - The accumulated result is lost.
  - Post-reset, the first ctl_r is honoured only from the second rising edge after deassertion.

## Structure
- Package alu_math_pkg holds:
  - opcode constants;
  - FSM state encoding (IDLE, OP_A, OP_B, COMPUTE, MUL_S, DIV_S, RESULT);
  - err_code constants.
- Sub-module alu_math_div: iterative restoring unsigned divider, parameter W=OP_W.
  - Ports: start, dividend, divisor, quotient, done.
  - done pulses after W cycles.
  - divisor=0 is detected in the top level before start.

## Test plan
All scenarios with OP_BYTES=2, RES_W=32.
- ADD, A=0x0003, B=0x0004, k=2, c=1 → result=0x0000000F, ready at u+3, err=0.
- SUB_BA, A=0x0005, B=0x0003, k=1, c=0 → result=0xFFFFFFFE.
- DIV_AB, A=100, B=7, k=3, c=2 → result=44 at u+20; busy high from opcode+2 through u+20.
- DIV_AB with B=0 after a prior result 0x2A → ready with err=1, err_code=2, result stays 0x2A; then CLR, ACCUM A=0x1234 twice → result=0x00002468.
- Opcode 0xA → err at +2 with err_code=1, busy never rises. Separately, ctl pulse during OP_B of a MUL 0x0010*0x0010 (k=1, c=0) → err_code=3, and the MUL still returns 0x00000100.
- rst_n low during DIV_S → all outputs 0 asynchronously; a new ADD afterwards completes with correct timing.

Source files
------------

// File: rtl/alu_math_pkg.sv
// Shared types for the byte-serial math unit: opcodes, FSM states, error codes.
package alu_math_pkg;

  typedef enum logic [3:0] {
    OPC_ADD    = 4'd0,
    OPC_SUB_AB = 4'd1,
    OPC_SUB_BA = 4'd2,
    OPC_MUL    = 4'd3,
    OPC_DIV_AB = 4'd4,
    OPC_DIV_BA = 4'd5,
    OPC_INC_A  = 4'd6,
    OPC_INC_B  = 4'd7,
    OPC_CLR    = 4'd8,
    OPC_ACCUM  = 4'd9
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_OP_A, ST_OP_B, ST_COMPUTE, ST_MUL_S, ST_DIV_S, ST_RESULT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_DIV0    = 2'd2,
    ERR_PROTO   = 2'd3
  } err_code_e;

  // Opcodes 10..15 are reserved and rejected at accept time.
  function automatic logic op_legal(input logic [3:0] raw);
    return raw <= 4'd9;
  endfunction

  function automatic logic uses_a(input opcode_e op);
    return !(op inside {OPC_INC_B, OPC_CLR});
  endfunction

  function automatic logic uses_b(input opcode_e op);
    return !(op inside {OPC_INC_A, OPC_CLR, OPC_ACCUM});
  endfunction

endpackage

// File: rtl/alu_math_div.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, done pulses W cycles after start.
module alu_math_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [W:0]    shifted, trial;

  // One restoring step per cycle while the counter runs; start reloads everything.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that leaves one unassigned infers a latch.
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      // A borrow out of bit W means the trial subtraction went negative: restore.
      if (trial[W]) begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end else begin
        rem_d = trial[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  // Divider state; reset aborts any division in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/alu_math_p.sv
// Byte-serial arithmetic unit: collects opcode and operands, computes k*f(A,B)+c modulo 2^RES_W.
module alu_math_p
  import alu_math_pkg::*;
#(
  parameter int OP_BYTES = 2,
  parameter int RES_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctl,
  input  logic [7:0]       dat,
  input  logic [7:0]       k_val,
  input  logic [7:0]       c_val,
  output logic [RES_W-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code
);
  localparam int         OP_W      = 8 * OP_BYTES;
  localparam logic [1:0] LAST_BYTE = 2'(OP_BYTES - 1);

  logic             ctl_q;
  logic [7:0]       dat_q, k_q, c_q;
  state_e           state_q, state_d;
  opcode_e          op_q, op_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic [7:0]       k_s_q, k_s_d, c_s_q, c_s_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             ready_q, ready_d, err_q, err_d;
  err_code_e        err_code_q, err_code_d;

  logic             is_div, div_zero, div_start, div_done, illegal, proto;
  logic [OP_W-1:0]  dvd, dvs, quotient;
  logic [RES_W-1:0] a_ext, b_ext, k_use, c_use, f_simple, f, calc;

  assign is_div    = (op_q == OPC_DIV_AB) || (op_q == OPC_DIV_BA);
  assign dvd       = (op_q == OPC_DIV_BA) ? b_q : a_q;
  assign dvs       = (op_q == OPC_DIV_BA) ? a_q : b_q;
  assign div_zero  = (state_q == ST_COMPUTE) && is_div && (dvs == '0);
  assign div_start = (state_q == ST_COMPUTE) && is_div && (dvs != '0);
  assign illegal   = (state_q == ST_IDLE) && ctl_q && !op_legal(dat_q[3:0]);
  assign proto     = (state_q != ST_IDLE) && ctl_q;

  alu_math_div #(.W(OP_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dvd),
    .divisor  (dvs),
    .quotient (quotient),
    .done     (div_done)
  );

  // Input sampling: every port is registered once before any use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= 1'b0;
      dat_q <= '0;
      k_q   <= '0;
      c_q   <= '0;
    end else begin
      ctl_q <= ctl;
      dat_q <= dat;
      k_q   <= k_val;
      c_q   <= c_val;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: skip operand phases the opcode does not use.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (ctl_q && op_legal(dat_q[3:0])) begin
          if (uses_a(opcode_e'(dat_q[3:0])))      state_d = ST_OP_A;
          else if (uses_b(opcode_e'(dat_q[3:0]))) state_d = ST_OP_B;
          else                                     state_d = ST_COMPUTE;
        end
      ST_OP_A:    if (cnt_q == LAST_BYTE) state_d = uses_b(op_q) ? ST_OP_B : ST_COMPUTE;
      ST_OP_B:    if (cnt_q == LAST_BYTE) state_d = ST_COMPUTE;
      ST_COMPUTE:
        if (is_div)              state_d = div_zero ? ST_RESULT : ST_DIV_S;
        else if (op_q == OPC_MUL) state_d = ST_MUL_S;
        else                     state_d = ST_RESULT;
      ST_MUL_S:   state_d = ST_RESULT;
      ST_DIV_S:   if (div_done) state_d = ST_RESULT;
      ST_RESULT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: operand shift-in MSB first, k/c capture in COMPUTE.
  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    k_s_d = k_s_q;
    c_s_d = c_s_q;
    case (state_q)
      ST_IDLE:
        if (ctl_q && op_legal(dat_q[3:0])) begin
          op_d  = opcode_e'(dat_q[3:0]);
          a_d   = '0;
          b_d   = '0;
          cnt_d = '0;
        end
      ST_OP_A: begin
        a_d   = OP_W'({a_q, dat_q});
        cnt_d = (cnt_q == LAST_BYTE) ? 2'd0 : cnt_q + 2'd1;
      end
      ST_OP_B: begin
        b_d   = OP_W'({b_q, dat_q});
        cnt_d = (cnt_q == LAST_BYTE) ? 2'd0 : cnt_q + 2'd1;
      end
      ST_COMPUTE: begin
        k_s_d = k_q;
        c_s_d = c_q;
      end
      default: ;
    endcase
  end

  // Result and status: loaded on the edge that enters RESULT, so they appear with ready.
  always_comb begin
    a_ext = RES_W'(a_q);
    b_ext = RES_W'(b_q);
    k_use = (state_q == ST_COMPUTE) ? RES_W'(k_q) : RES_W'(k_s_q);
    c_use = (state_q == ST_COMPUTE) ? RES_W'(c_q) : RES_W'(c_s_q);
    case (op_q)
      OPC_SUB_AB: f_simple = a_ext - b_ext;
      OPC_SUB_BA: f_simple = b_ext - a_ext;
      OPC_INC_A:  f_simple = a_ext + RES_W'(1);
      OPC_INC_B:  f_simple = b_ext + RES_W'(1);
      default:    f_simple = a_ext + b_ext;
    endcase
    case (state_q)
      ST_MUL_S: f = a_ext * b_ext;
      ST_DIV_S: f = RES_W'(quotient);
      default:  f = f_simple;
    endcase
    calc = k_use * f + c_use;
    if (op_q == OPC_ACCUM) calc = result_q + a_ext;
    if (op_q == OPC_CLR)   calc = '0;

    ready_d  = (state_d == ST_RESULT);
    result_d = (ready_d && !div_zero) ? calc : result_q;
    err_d    = illegal || proto || div_zero;

    err_code_d = err_code_q;
    if (ready_d && !div_zero) err_code_d = ERR_NONE;
    if (illegal)              err_code_d = ERR_ILLEGAL;
    if (proto)                err_code_d = ERR_PROTO;
    if (div_zero)             err_code_d = ERR_DIV0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OPC_ADD;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      k_s_q      <= '0;
      c_s_q      <= '0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      k_s_q      <= k_s_d;
      c_s_q      <= c_s_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign result   = result_q;
  assign ready    = ready_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule
